// File: rtl/bird_sprite_sequencer.sv
// Draws, waits, erases and advances a 13-pixel bird sprite on the 160x120 framebuffer,
// one pixel per clock, until the bird is hit or leaves the right edge.
module bird_sprite_sequencer #(
   parameter int unsigned FRAME_CYCLES = 833334,
   parameter int unsigned MOVE_FRAMES  = 4,
   parameter int unsigned STEP         = 2,
   parameter int unsigned X_START      = 5,
   parameter int unsigned X_MAX        = 159,
   parameter logic [2:0]  BIRD_COLOUR  = 3'b111,
   parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] start_y,
   input  logic       hit,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic [7:0] bird_x,
   output logic       killed,
   output logic       escaped
);
   localparam int unsigned TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int unsigned FW = $clog2(MOVE_FRAMES + 1);
   localparam logic [3:0] LAST_IDX = 4'd12;

   typedef enum logic [2:0] {StIdle, StDraw, StWait, StErase, StUpdate} state_e;

   state_e        r_state, w_state_d;
   logic [3:0]    r_idx, w_idx_d;
   logic [7:0]    r_ax, w_ax_d;
   logic [6:0]    r_ay, w_ay_d;
   logic [TW-1:0] r_timer, w_timer_d;
   logic [FW-1:0] r_fcount, w_fcount_d;
   logic          r_hit_pending, w_hit_pending_d;

   logic       w_tick;
   logic [8:0] w_nx;
   logic [6:0] w_y_clamped;
   logic [2:0] w_dx;
   logic       w_dy_inc, w_dy_dec;

   assign w_tick      = (r_timer == TW'(FRAME_CYCLES - 1));
   assign w_nx        = {1'b0, r_ax} + 9'(STEP);
   assign w_y_clamped = (start_y < 7'd1) ? 7'd1 : ((start_y > 7'd118) ? 7'd118 : start_y);

   // Sprite shape: w_dx is a leftward offset, y offset is -1/0/+1.
   always_comb begin
      w_dx     = 3'd0;
      w_dy_inc = 1'b0;
      w_dy_dec = 1'b0;
      case (r_idx)
         4'd1:    w_dy_inc = 1'b1;
         4'd2:    w_dx = 3'd1;
         4'd3:    w_dx = 3'd2;
         4'd4:    w_dx = 3'd3;
         4'd5:    w_dx = 3'd4;
         4'd6:    w_dx = 3'd5;
         4'd7:    begin w_dx = 3'd3; w_dy_inc = 1'b1; end
         4'd8:    begin w_dx = 3'd3; w_dy_dec = 1'b1; end
         4'd9:    begin w_dx = 3'd4; w_dy_inc = 1'b1; end
         4'd10:   begin w_dx = 3'd4; w_dy_dec = 1'b1; end
         4'd11:   begin w_dx = 3'd5; w_dy_inc = 1'b1; end
         4'd12:   begin w_dx = 3'd5; w_dy_dec = 1'b1; end
         default: w_dx = 3'd0;
      endcase
   end

   always_comb begin
      plot   = 1'b0;
      x_out  = 8'd0;
      y_out  = 7'd0;
      colour = BG_COLOUR;
      if (r_state == StDraw || r_state == StErase) begin
         plot  = 1'b1;
         x_out = r_ax - {5'd0, w_dx};
         if (w_dy_inc) begin
            y_out = r_ay + 7'd1;
         end else if (w_dy_dec) begin
            y_out = r_ay - 7'd1;
         end else begin
            y_out = r_ay;
         end
      end
      if (r_state == StDraw) begin
         colour = BIRD_COLOUR;
      end
   end

   assign busy    = (r_state != StIdle);
   assign bird_x  = busy ? r_ax : 8'd0;
   assign killed  = (r_state == StUpdate) && r_hit_pending;
   assign escaped = (r_state == StUpdate) && !r_hit_pending && (w_nx > 9'(X_MAX));

   always_comb begin
      w_state_d       = r_state;
      w_idx_d         = r_idx;
      w_ax_d          = r_ax;
      w_ay_d          = r_ay;
      w_fcount_d      = r_fcount;
      w_timer_d       = w_tick ? '0 : r_timer + TW'(1);
      w_hit_pending_d = r_hit_pending | hit;
      unique case (r_state)
         StIdle: begin
            w_timer_d       = '0;
            w_hit_pending_d = 1'b0;
            if (start) begin
               w_state_d  = StDraw;
               w_idx_d    = 4'd0;
               w_ax_d     = 8'(X_START);
               w_ay_d     = w_y_clamped;
               w_fcount_d = '0;
            end
         end
         StDraw, StErase: begin
            if (r_idx == LAST_IDX) begin
               w_idx_d   = 4'd0;
               w_state_d = (r_state == StDraw) ? StWait : StUpdate;
            end else begin
               w_idx_d = r_idx + 4'd1;
            end
         end
         StWait: begin
            // Only ticks seen while waiting count towards the next move.
            if (w_tick) begin
               if (r_fcount == FW'(MOVE_FRAMES - 1) || r_hit_pending) begin
                  w_fcount_d = '0;
                  w_state_d  = StErase;
               end else begin
                  w_fcount_d = r_fcount + FW'(1);
               end
            end
         end
         StUpdate: begin
            if (r_hit_pending || (w_nx > 9'(X_MAX))) begin
               w_state_d       = StIdle;
               w_hit_pending_d = 1'b0;
            end else begin
               w_ax_d    = w_nx[7:0];
               w_state_d = StDraw;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state       <= StIdle;
         r_idx         <= 4'd0;
         r_ax          <= 8'd0;
         r_ay          <= 7'd0;
         r_timer       <= '0;
         r_fcount      <= '0;
         r_hit_pending <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_idx         <= w_idx_d;
         r_ax          <= w_ax_d;
         r_ay          <= w_ay_d;
         r_timer       <= w_timer_d;
         r_fcount      <= w_fcount_d;
         r_hit_pending <= w_hit_pending_d;
      end
   end

endmodule

// File: tb/tb_bird_sprite_sequencer.sv
// Bench for bird_sprite_sequencer: table of spawn pixels, hand-built lifecycle sequences,
// and a randomized run checked against a queue-based behavioural model.
module tb_bird_sprite_sequencer;
   localparam int FC  = 100;
   localparam int MF  = 2;
   localparam int STP = 2;
   localparam int XS  = 5;
   localparam int XMX = 159;
   localparam int FC2 = 20;
   localparam int MF2 = 1;
   localparam int XS2 = 157;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, hit, start2, hit2;
   logic [6:0] start_y;
   logic [7:0] a_x, a_bx, b_x, b_bx;
   logic [6:0] a_y, b_y;
   logic [2:0] a_col, b_col;
   logic       a_plot, a_busy, a_kill, a_esc, b_plot, b_busy, b_kill, b_esc;

   bird_sprite_sequencer #(
      .FRAME_CYCLES(FC), .MOVE_FRAMES(MF), .STEP(STP), .X_START(XS), .X_MAX(XMX),
      .BIRD_COLOUR(3'b111), .BG_COLOUR(3'b000)
   ) u_dut_a (
      .CLOCK_50(clk), .reset(rst), .start(start), .start_y(start_y), .hit(hit),
      .x_out(a_x), .y_out(a_y), .colour(a_col), .plot(a_plot), .busy(a_busy),
      .bird_x(a_bx), .killed(a_kill), .escaped(a_esc)
   );

   bird_sprite_sequencer #(
      .FRAME_CYCLES(FC2), .MOVE_FRAMES(MF2), .STEP(STP), .X_START(XS2), .X_MAX(XMX),
      .BIRD_COLOUR(3'b111), .BG_COLOUR(3'b000)
   ) u_dut_b (
      .CLOCK_50(clk), .reset(rst), .start(start2), .start_y(start_y), .hit(hit2),
      .x_out(b_x), .y_out(b_y), .colour(b_col), .plot(b_plot), .busy(b_busy),
      .bird_x(b_bx), .killed(b_kill), .escaped(b_esc)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Behavioural model: pixel bursts come from a queue built from the sprite table,
   // the frame timer is derived arithmetically from the spawn edge.
   typedef struct {int x; int y; int c;} pix_t;
   localparam int KIdle = 0, KDraw = 1, KWait = 2, KErase = 3, KUpd = 4;
   int   dxo[13] = '{0, 0, 1, 2, 3, 4, 5, 3, 3, 4, 4, 5, 5};
   int   dyo[13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 1, -1, 1, -1};
   pix_t mq[$];
   pix_t m_pix;
   int   m_kind = KIdle;
   int   m_ax, m_ay, m_pend, m_ticks, m_t0, m_kill, m_esc;

   task automatic burst(input int col);
      pix_t p;
      for (int i = 0; i < 13; i++) begin
         p.x = m_ax - dxo[i];
         p.y = m_ay + dyo[i];
         p.c = col;
         mq.push_back(p);
      end
   endtask

   task automatic model_step(input bit r, input bit s, input int sy, input bit h, input int n);
      int pend_old;
      bit tick;
      if (r) begin
         m_kind = KIdle;
         m_pend = 0;
         mq.delete();
         return;
      end
      if (m_kind == KIdle) begin
         if (s) begin
            m_ax    = XS;
            m_ay    = (sy < 1) ? 1 : ((sy > 118) ? 118 : sy);
            m_pend  = 0;
            m_ticks = 0;
            m_t0    = n;
            burst(7);
            m_pix  = mq.pop_front();
            m_kind = KDraw;
         end
         return;
      end
      pend_old = m_pend;
      if (h) m_pend = 1;
      tick = ((n - 1 - m_t0) % FC) == FC - 1;
      case (m_kind)
         KDraw, KErase: begin
            if (mq.size() > 0) begin
               m_pix = mq.pop_front();
            end else if (m_kind == KDraw) begin
               m_kind = KWait;
            end else begin
               m_kind = KUpd;
               m_kill = m_pend;
               m_esc  = (m_pend == 0 && m_ax + STP > XMX) ? 1 : 0;
            end
         end
         KWait: begin
            if (tick) begin
               if (m_ticks == MF - 1 || pend_old != 0) begin
                  m_ticks = 0;
                  burst(0);
                  m_pix  = mq.pop_front();
                  m_kind = KErase;
               end else begin
                  m_ticks++;
               end
            end
         end
         KUpd: begin
            if (m_kill != 0 || m_esc != 0) begin
               m_kind = KIdle;
               m_pend = 0;
            end else begin
               m_ax = m_ax + STP;
               burst(7);
               m_pix  = mq.pop_front();
               m_kind = KDraw;
            end
         end
         default: m_kind = KIdle;
      endcase
   endtask

   typedef struct {int sy; int idx; int ex; int ey;} vec_t;

   initial begin
      vec_t vt[12];
      int   n_draw, n_erase, n_plot, first_erase, kill_obs, n_kill, n_esc, esc_obs, max_x;
      int   hold;
      bit   e_plot, e_busy;

      rst = 1'b1; start = 1'b0; hit = 1'b0; start2 = 1'b0; hit2 = 1'b0; start_y = 7'd0;
      step();
      step();
      chk("rst_plot", a_plot, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_killed", a_kill, 0);
      chk("rst_escaped", a_esc, 0);
      chk("rst_x", a_x, 0);
      chk("rst_y", a_y, 0);
      chk("rst_colour", a_col, 0);
      chk("rst_bird_x", a_bx, 0);

      // Spawn pixel table: {start_y, pixel index, expected x, expected y}
      vt[0]  = '{50, 0, 5, 50};
      vt[1]  = '{50, 12, 0, 49};
      vt[2]  = '{0, 12, 0, 0};
      vt[3]  = '{0, 0, 5, 1};
      vt[4]  = '{127, 1, 5, 119};
      vt[5]  = '{127, 0, 5, 118};
      vt[6]  = '{1, 8, 2, 0};
      vt[7]  = '{118, 7, 2, 119};
      vt[8]  = '{64, 6, 0, 64};
      vt[9]  = '{117, 9, 1, 118};
      vt[10] = '{90, 2, 4, 90};
      vt[11] = '{33, 11, 0, 34};
      for (int v = 0; v < 12; v++) begin
         rst = 1'b1; step(); rst = 1'b0;
         start_y = 7'(vt[v].sy); start = 1'b1; step(); start = 1'b0;
         repeat (vt[v].idx) step();
         chk($sformatf("vec%0d_plot", v), a_plot, 1);
         chk($sformatf("vec%0d_colour", v), a_col, 7);
         chk($sformatf("vec%0d_x", v), a_x, vt[v].ex);
         chk($sformatf("vec%0d_y", v), a_y, vt[v].ey);
      end

      // Draw length, move timing, erase and redraw one step to the right
      rst = 1'b1; step(); rst = 1'b0;
      start_y = 7'd50; start = 1'b1; step(); start = 1'b0;
      n_draw = 0; n_erase = 0; first_erase = 0;
      for (int obs = 1; obs <= 230; obs++) begin
         if (obs <= 20 && a_plot) n_draw++;
         if (a_plot && a_col == 3'b000) begin
            n_erase++;
            if (first_erase == 0) begin
               first_erase = obs;
               chk("erase_x0", a_x, 5);
               chk("erase_y0", a_y, 50);
            end
         end
         if (first_erase != 0 && obs == first_erase + 13) begin
            chk("update_plot", a_plot, 0);
            chk("update_busy", a_busy, 1);
         end
         if (first_erase != 0 && obs == first_erase + 14) begin
            chk("redraw_plot", a_plot, 1);
            chk("redraw_x", a_x, 7);
            chk("redraw_colour", a_col, 7);
            chk("redraw_bird_x", a_bx, 7);
         end
         step();
      end
      chk("draw_len", n_draw, 13);
      chk("erase_start", first_erase, 201);
      chk("erase_len", n_erase, 13);

      // Hit during DRAW, then again while pending: one early erase, one killed pulse
      rst = 1'b1; step(); rst = 1'b0;
      start_y = 7'd50; start = 1'b1; step(); start = 1'b0;
      n_plot = 0; first_erase = 0; kill_obs = 0; n_kill = 0;
      for (int obs = 1; obs <= 300; obs++) begin
         if (a_plot) n_plot++;
         if (first_erase == 0 && a_plot && a_col == 3'b000) first_erase = obs;
         if (a_kill) begin
            n_kill++;
            if (kill_obs == 0) kill_obs = obs;
         end
         if (kill_obs != 0 && obs == kill_obs + 1) chk("kill_then_idle_busy", a_busy, 0);
         hit = (obs == 5 || obs == 50);
         step();
      end
      hit = 1'b0;
      chk("hit_erase_start", first_erase, 101);
      chk("kill_obs", kill_obs, 114);
      chk("kill_count", n_kill, 1);
      chk("hit_plot_total", n_plot, 26);

      // Escape on the second instance: drawn at 159, erased, never drawn at 161
      rst = 1'b1; step(); rst = 1'b0;
      start_y = 7'd60; start2 = 1'b1; step(); start2 = 1'b0;
      n_plot = 0; n_esc = 0; esc_obs = 0; max_x = 0; n_kill = 0;
      for (int obs = 1; obs <= 120; obs++) begin
         if (b_plot) begin
            n_plot++;
            if (int'(b_x) > max_x) max_x = int'(b_x);
         end
         if (b_esc) begin
            n_esc++;
            if (esc_obs == 0) esc_obs = obs;
         end
         if (b_kill) n_kill++;
         if (obs == 35) chk("esc_bird_x_159", b_bx, 159);
         if (esc_obs != 0 && obs == esc_obs + 1) chk("esc_then_idle_busy", b_busy, 0);
         step();
      end
      chk("esc_plot_total", n_plot, 52);
      chk("esc_count", n_esc, 1);
      chk("esc_obs", esc_obs, 74);
      chk("esc_max_x", max_x, 159);
      chk("esc_kill_count", n_kill, 0);

      // Reset at DRAW index 6, then an immediate fresh spawn
      rst = 1'b1; step(); rst = 1'b0;
      start_y = 7'd50; start = 1'b1; step(); start = 1'b0;
      repeat (6) step();
      chk("mid_draw_x_idx6", a_x, 0);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_rst_plot", a_plot, 0);
      chk("mid_rst_busy", a_busy, 0);
      start = 1'b1; step(); start = 1'b0;
      chk("respawn_x0", a_x, 5);
      chk("respawn_y0", a_y, 50);
      n_plot = 0;
      for (int obs = 1; obs <= 20; obs++) begin
         if (a_plot) n_plot++;
         step();
      end
      chk("respawn_len", n_plot, 13);

      // Randomized run against the model
      hold = 0;
      for (int n = 0; n < 15000; n++) begin
         rst   = (n == 0) || ($urandom_range(0, 2999) == 0);
         start = ($urandom_range(0, 7) == 0);
         start_y = 7'($urandom_range(0, 127));
         if (hold > 0) begin
            hit = 1'b1;
            hold--;
         end else if ($urandom_range(0, 599) == 0) begin
            hit  = 1'b1;
            hold = $urandom_range(0, 3);
         end else begin
            hit = 1'b0;
         end
         @(posedge clk);
         model_step(rst, start, int'(start_y), hit, n);
         @(negedge clk);
         e_busy = (m_kind != KIdle);
         e_plot = (m_kind == KDraw || m_kind == KErase);
         chk("rnd_busy", a_busy, e_busy);
         chk("rnd_plot", a_plot, e_plot);
         chk("rnd_bird_x", a_bx, e_busy ? m_ax : 0);
         chk("rnd_killed", a_kill, (m_kind == KUpd && m_kill != 0) ? 1 : 0);
         chk("rnd_escaped", a_esc, (m_kind == KUpd && m_esc != 0) ? 1 : 0);
         if (e_plot) begin
            chk("rnd_x", a_x, m_pix.x);
            chk("rnd_y", a_y, m_pix.y);
            chk("rnd_colour", a_col, m_pix.c);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bird_sprite_sequencer.md
Name: bird_sprite_sequencer

Overview:
- Sequences the on-screen life of one bird sprite on the 160x120 VGA framebuffer: draw, wait N frames, erase, advance, redraw, until the bird is hit or leaves the right edge.
- Sole driver of the vga_adapter plot port (x, y, colour, plot).
- Sits between game logic (start, start_y, hit) and the VGA adapter.
- Writes one pixel per clock.

Parameters:
- FRAME_CYCLES, 833334: clocks per frame tick (50 MHz / 60).
- MOVE_FRAMES, 4: frame ticks between moves, must be >= 1.
- STEP, 2: pixels added to anchor x per move.
- X_START, 5: anchor x on spawn, must be >= 5.
- X_MAX, 159: largest legal anchor x.
- BIRD_COLOUR, 3'b111: colour used when drawing.
- BG_COLOUR, 3'b000: colour used when erasing.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  spawn request; sampled only in IDLE
- start_y  in  7  requested anchor row
- hit  in  1  shot landed; one-cycle pulse or level
- x_out  out  8  pixel x to VGA adapter
- y_out  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour
- plot  out  1  write enable to VGA adapter
- busy  out  1  high in every state except IDLE
- bird_x  out  8  current anchor x
- killed  out  1  one-cycle pulse: bird removed after hit
- escaped  out  1  one-cycle pulse: bird passed X_MAX

Behaviour:
- Sprite is 13 pixels. Index i gives offset (dx,dy) from anchor (ax,ay):
  - 0:(0,0), 1:(0,+1), 2:(-1,0), 3:(-2,0), 4:(-3,0), 5:(-4,0), 6:(-5,0)
  - 7:(-3,+1), 8:(-3,-1), 9:(-4,+1), 10:(-4,-1), 11:(-5,+1), 12:(-5,-1)
- Offsets come from a combinational table on a 4-bit pixel index. x_out = ax+dx (8 bit), y_out = ay+dy (7 bit).
- Reset (synchronous, any state): state=IDLE, plot=0, busy=0, killed=0, escaped=0, x_out=0, y_out=0, colour=BG_COLOUR, bird_x=0, hit_pending=0, frame timer=0, frame count=0. Pixels already written stay in the framebuffer.
- State machine:
  - IDLE: when start=1, load ax=X_START and ay=clamp(start_y,1,118), clear frame timer and frame count, clear hit_pending, go to DRAW.
  - DRAW: plot=1, colour=BIRD_COLOUR. Index steps 0..12, one per clock, 13 consecutive clocks. After index 12, go to WAIT.
  - WAIT: plot=0. On each frame tick, increment frame count. When a tick arrives and either frame count = MOVE_FRAMES-1 or hit_pending=1: clear frame count, go to ERASE.
  - ERASE: same 13 pixels as DRAW, colour=BG_COLOUR, plot=1. Then go to UPDATE.
  - UPDATE: one clock, plot=0.
    - If hit_pending=1: killed=1 for this clock, go to IDLE.
    - Otherwise compute nx = ax+STEP in 9 bits. If nx > X_MAX: escaped=1, go to IDLE. Else ax=nx, go to DRAW.
- Frame timer:
  - Free-runs 0..FRAME_CYCLES-1 in all states except IDLE, and wraps.
  - Tick = timer at FRAME_CYCLES-1.
  - Ticks during DRAW, ERASE or UPDATE are not counted.
- Timing: outputs are a function of the registered state and index. If start is sampled at edge k, pixel i appears in cycle k+1+i, with plot high in cycles k+1..k+13.
- hit:
  - Any hit while busy sets hit_pending, which stays set until IDLE.
  - hit in IDLE is ignored.
  - hit in the same cycle as start is ignored (hit_pending is cleared on spawn).
- start while busy is ignored.
- Bounds:
  - X_START >= 5 and the y clamp keep all pixels on screen; no clipping logic.
  - Anchor never exceeds X_MAX when drawn.
- bird_x = ax while busy, else 0.

Test Plan:
- FRAME_CYCLES=100, MOVE_FRAMES=2, STEP=2. start with start_y=50 → plot high exactly 13 cycles; pixel 0 at (5,50), pixel 12 at (0,49), colour 111.
- Same config → after the 2nd frame tick: 13-cycle erase at x=5 with colour 000, then redraw at anchor (7,50); bird_x=7.
- start_y=0 → ay=1, pixel 12 at y=0. start_y=127 → ay=118, pixel 1 at y=119.
- hit pulse mid-DRAW → at the next frame tick (not waiting MOVE_FRAMES): erase, then killed pulses exactly 1 cycle, then IDLE with busy=0. Second hit while pending → single killed pulse.
- X_START=157, STEP=2 → first move gives nx=159 and the bird is drawn; next move gives nx=161 → erase, escaped pulses 1 cycle, no draw at 161.
- reset asserted at DRAW index 6 → next cycle plot=0, busy=0, IDLE. start in the following cycle → full 13-pixel draw from index 0.
